axi_rd_arbiter: RTL and testbench

Shares the single AXI4 master read channel (AR/R) of the core between two requesters: instruction fetch (port 0) and a data-load unit (port 1). Accepts one single-beat read request at a time, presents it on AR, collects the R beat and returns data and response to the owning requester. Sits between the requesters and the M_AXI_AR*/M_AXI_R* core ports. Arbitration is round-robin with at most one outstanding transaction.

---
 rtl/axi_rd_arbiter_pkg.sv | 19 +
 rtl/rr_arb2.sv | 16 +
 rtl/axi_rd_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 496 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types and AXI constants for the two-port AXI read arbiter.
// FSM encodings and fixed single-beat AR attributes live here.
package axi_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_AR   = 2'b01,
        S_R    = 2'b11
    } state_t;

    localparam logic [7:0] AXI_ARLEN   = 8'd0;
    localparam logic [2:0] AXI_ARSIZE  = 3'b010;
    localparam logic [1:0] AXI_INCR    = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin select.
// On a tie the port that was not served last wins.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic sel_valid,
    output logic sel_idx
);

    always_comb begin
        sel_valid = req0 | req1;
        sel_idx   = (req0 & req1) ? ~last : req1;
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read channel between fetch (port 0) and load (port 1).
// One single-beat transaction in flight, round-robin between requesters.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  R0_REQ,
    input  logic [ADDR_WIDTH-1:0] R0_ADDR,
    output logic                  R0_GNT,
    output logic                  R0_VALID,
    output logic [DATA_WIDTH-1:0] R0_DATA,
    output logic [1:0]            R0_RESP,
    input  logic                  R1_REQ,
    input  logic [ADDR_WIDTH-1:0] R1_ADDR,
    output logic                  R1_GNT,
    output logic                  R1_VALID,
    output logic [DATA_WIDTH-1:0] R1_DATA,
    output logic [1:0]            R1_RESP,
    output logic [ID_WIDTH-1:0]   M_AXI_ARID,
    output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [7:0]            M_AXI_ARLEN,
    output logic [2:0]            M_AXI_ARSIZE,
    output logic [1:0]            M_AXI_ARBURST,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RLAST,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY,
    output logic                  ERR_RLAST
);

    state_t                state_q, state_d;
    logic                  last_q, last_d;
    logic                  owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [ID_WIDTH-1:0]   arid_q, arid_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  gnt0_q, gnt0_d;
    logic                  gnt1_q, gnt1_d;
    logic                  val0_q, val0_d;
    logic                  val1_q, val1_d;
    logic [DATA_WIDTH-1:0] data0_q, data0_d;
    logic [DATA_WIDTH-1:0] data1_q, data1_d;
    logic [1:0]            resp0_q, resp0_d;
    logic [1:0]            resp1_q, resp1_d;
    logic                  err_q, err_d;

    logic                  sel_valid;
    logic                  sel_idx;

    rr_arb2 u_rr (
        .req0      (R0_REQ),
        .req1      (R1_REQ),
        .last      (last_q),
        .sel_valid (sel_valid),
        .sel_idx   (sel_idx)
    );

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        araddr_d  = araddr_q;
        arid_d    = arid_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        val0_d    = 1'b0;
        val1_d    = 1'b0;
        data0_d   = data0_q;
        data1_d   = data1_q;
        resp0_d   = resp0_q;
        resp1_d   = resp1_q;
        err_d     = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (sel_valid) begin
                    owner_d   = sel_idx;
                    araddr_d  = sel_idx ? R1_ADDR : R0_ADDR;
                    arid_d    = '0;
                    arid_d[0] = sel_idx;
                    gnt0_d    = ~sel_idx;
                    gnt1_d    = sel_idx;
                    arvalid_d = 1'b1;
                    state_d   = S_AR;
                end
            end
            S_AR: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_R;
                end
            end
            S_R: begin
                if (M_AXI_RVALID) begin
                    if (owner_q) begin
                        data1_d = M_AXI_RDATA;
                        resp1_d = M_AXI_RRESP;
                        val1_d  = 1'b1;
                    end else begin
                        data0_d = M_AXI_RDATA;
                        resp0_d = M_AXI_RRESP;
                        val0_d  = 1'b1;
                    end
                    // Single-beat reads only; a missing RLAST is a fabric bug.
                    err_d    = err_q | ~M_AXI_RLAST;
                    rready_d = 1'b0;
                    last_d   = owner_q;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            araddr_q  <= '0;
            arid_q    <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            val0_q    <= 1'b0;
            val1_q    <= 1'b0;
            data0_q   <= '0;
            data1_q   <= '0;
            resp0_q   <= 2'b00;
            resp1_q   <= 2'b00;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            araddr_q  <= araddr_d;
            arid_q    <= arid_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            val0_q    <= val0_d;
            val1_q    <= val1_d;
            data0_q   <= data0_d;
            data1_q   <= data1_d;
            resp0_q   <= resp0_d;
            resp1_q   <= resp1_d;
            err_q     <= err_d;
        end
    end

    assign R0_GNT        = gnt0_q;
    assign R1_GNT        = gnt1_q;
    assign R0_VALID      = val0_q;
    assign R1_VALID      = val1_q;
    assign R0_DATA       = data0_q;
    assign R1_DATA       = data1_q;
    assign R0_RESP       = resp0_q;
    assign R1_RESP       = resp1_q;
    assign M_AXI_ARID    = arid_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARLEN   = AXI_ARLEN;
    assign M_AXI_ARSIZE  = AXI_ARSIZE;
    assign M_AXI_ARBURST = AXI_INCR;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;
    assign ERR_RLAST     = err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter with a configurable AXI slave.
// Grants and returned beats are popped from expectation queues.
module tb_axi_rd_arbiter;
    import axi_rd_arbiter_pkg::*;

    logic        CLK;
    logic        RST;
    logic        R0_REQ, R1_REQ;
    logic [31:0] R0_ADDR, R1_ADDR;
    logic        R0_GNT, R1_GNT;
    logic        R0_VALID, R1_VALID;
    logic [31:0] R0_DATA, R1_DATA;
    logic [1:0]  R0_RESP, R1_RESP;
    logic [0:0]  M_AXI_ARID;
    logic [31:0] M_AXI_ARADDR;
    logic [7:0]  M_AXI_ARLEN;
    logic [2:0]  M_AXI_ARSIZE;
    logic [1:0]  M_AXI_ARBURST;
    logic        M_AXI_ARVALID, M_AXI_ARREADY;
    logic [31:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;
    logic        ERR_RLAST;

    axi_rd_arbiter dut (
        .CLK(CLK), .RST(RST),
        .R0_REQ(R0_REQ), .R0_ADDR(R0_ADDR), .R0_GNT(R0_GNT),
        .R0_VALID(R0_VALID), .R0_DATA(R0_DATA), .R0_RESP(R0_RESP),
        .R1_REQ(R1_REQ), .R1_ADDR(R1_ADDR), .R1_GNT(R1_GNT),
        .R1_VALID(R1_VALID), .R1_DATA(R1_DATA), .R1_RESP(R1_RESP),
        .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR),
        .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARSIZE(M_AXI_ARSIZE),
        .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARVALID(M_AXI_ARVALID),
        .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA),
        .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
        .ERR_RLAST(ERR_RLAST)
    );

    typedef struct {
        int          port;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    exp_t sb[$];
    int   gq[$];
    int   checks = 0;
    int   failures = 0;

    int          ar_wait = 0;
    int          r_wait = 0;
    logic [1:0]  resp_cfg = 2'b00;
    logic        rlast_cfg = 1'b1;
    int          sl_st, sl_cnt;
    logic [31:0] sl_addr;

    exp_t        mon_e;
    int          mon_p;
    logic [31:0] mon_d;
    logic [1:0]  mon_r;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] fdat(input logic [31:0] a);
        return a ^ 32'hDEADBFEF;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // AXI slave: fixed ARREADY/RVALID delays, data derived from address.
    initial begin
        M_AXI_ARREADY = 1'b0;
        M_AXI_RVALID  = 1'b0;
        M_AXI_RDATA   = '0;
        M_AXI_RRESP   = 2'b00;
        M_AXI_RLAST   = 1'b0;
        sl_st = 0;
        sl_cnt = 0;
        sl_addr = '0;
        forever begin
            tick();
            if (RST) begin
                M_AXI_ARREADY = 1'b0;
                M_AXI_RVALID  = 1'b0;
                sl_st = 0;
                sl_cnt = 0;
            end else begin
                if (sl_st == 2) begin
                    M_AXI_RVALID = 1'b0;
                    sl_st = 0;
                    sl_cnt = 0;
                end
                if (sl_st == 3) begin
                    M_AXI_ARREADY = 1'b0;
                    sl_st = 1;
                    sl_cnt = 0;
                end
                if (sl_st == 1) begin
                    if (!M_AXI_RREADY) begin
                        M_AXI_RVALID = 1'b0;
                        sl_st = 0;
                        sl_cnt = 0;
                    end else if (sl_cnt == r_wait) begin
                        M_AXI_RVALID = 1'b1;
                        M_AXI_RDATA  = fdat(sl_addr);
                        M_AXI_RRESP  = resp_cfg;
                        M_AXI_RLAST  = rlast_cfg;
                        sl_st = 2;
                    end else begin
                        sl_cnt++;
                    end
                end else if (sl_st == 0 && M_AXI_ARVALID) begin
                    if (sl_cnt == ar_wait) begin
                        M_AXI_ARREADY = 1'b1;
                        sl_addr = M_AXI_ARADDR;
                        sl_st = 3;
                    end else begin
                        M_AXI_ARREADY = 1'b0;
                        sl_cnt++;
                    end
                end
            end
        end
    end

    // Monitor: grant order and returned beats against the queues.
    always @(negedge CLK) begin
        if (R0_GNT || R1_GNT) begin
            checks++;
            if (gq.size() == 0) begin
                failures++;
                $display("FAIL gnt_unexpected: got r0=%0b r1=%0b, none expected",
                         R0_GNT, R1_GNT);
            end else begin
                mon_p = gq.pop_front();
                if ((R0_GNT && R1_GNT) || (mon_p == 0 ? !R0_GNT : !R1_GNT)) begin
                    failures++;
                    $display("FAIL gnt_order: got r0=%0b r1=%0b, expected port %0d",
                             R0_GNT, R1_GNT, mon_p);
                end
            end
        end
        if (R0_VALID || R1_VALID) begin
            checks++;
            mon_p = R1_VALID ? 1 : 0;
            mon_d = R1_VALID ? R1_DATA : R0_DATA;
            mon_r = R1_VALID ? R1_RESP : R0_RESP;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL valid_unexpected: got r0=%0b r1=%0b, none expected",
                         R0_VALID, R1_VALID);
            end else begin
                mon_e = sb.pop_front();
                if ((R0_VALID && R1_VALID) || mon_p != mon_e.port ||
                    mon_d !== mon_e.data || mon_r !== mon_e.resp) begin
                    failures++;
                    $display("FAIL beat: got port=%0d data=%h resp=%0d, expected port=%0d data=%h resp=%0d",
                             mon_p, mon_d, mon_r, mon_e.port, mon_e.data, mon_e.resp);
                end
            end
        end
    end

    task automatic issue(input int port, input logic [31:0] addr,
                         input logic [1:0] resp);
        bit got;
        exp_t e;
        e.port = port;
        e.data = fdat(addr);
        e.resp = resp;
        sb.push_back(e);
        gq.push_back(port);
        if (port == 0) begin
            R0_ADDR = addr;
            R0_REQ = 1'b1;
        end else begin
            R1_ADDR = addr;
            R1_REQ = 1'b1;
        end
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            tick();
            got = (port == 0) ? R0_GNT : R1_GNT;
        end
        R0_REQ = 1'b0;
        R1_REQ = 1'b0;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout: port %0d got no grant, expected one", port);
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            done = sb.size() == 0 && gq.size() == 0 &&
                   !M_AXI_ARVALID && !M_AXI_RREADY;
            if (!done) tick();
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL drain_timeout: got %0d beats pending, expected 0",
                     sb.size());
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        sb.delete();
        gq.delete();
        tick();
        tick();
        RST = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        checks++;
        if ({M_AXI_ARVALID, M_AXI_RREADY, R0_GNT, R1_GNT,
             R0_VALID, R1_VALID, ERR_RLAST} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b, expected 0000000",
                     {M_AXI_ARVALID, M_AXI_RREADY, R0_GNT, R1_GNT,
                      R0_VALID, R1_VALID, ERR_RLAST});
        end
        checks++;
        if (R0_DATA !== 32'h0 || R1_DATA !== 32'h0 ||
            R0_RESP !== 2'b0 || R1_RESP !== 2'b0) begin
            failures++;
            $display("FAIL reset_data: got %h %h %0d %0d, expected zeros",
                     R0_DATA, R1_DATA, R0_RESP, R1_RESP);
        end
        checks++;
        if (M_AXI_ARADDR !== 32'h0 || M_AXI_ARID !== 1'b0) begin
            failures++;
            $display("FAIL reset_ar: got addr=%h id=%0d, expected 0/0",
                     M_AXI_ARADDR, M_AXI_ARID);
        end
        checks++;
        if (M_AXI_ARLEN !== 8'd0 || M_AXI_ARSIZE !== 3'b010 ||
            M_AXI_ARBURST !== 2'b01) begin
            failures++;
            $display("FAIL ar_const: got len=%0d size=%0d burst=%0d, expected 0/2/1",
                     M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST);
        end
        RST = 1'b0;
        tick();
        checks++;
        if (M_AXI_ARVALID !== 1'b0 || R0_GNT !== 1'b0 || R1_GNT !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_req: got arvalid=%0b gnt=%0b%0b, expected 0",
                     M_AXI_ARVALID, R0_GNT, R1_GNT);
        end
    endtask

    task automatic test_single();
        exp_t e;
        e.port = 0;
        e.data = 32'hDEADBEEF;
        e.resp = RESP_OKAY;
        sb.push_back(e);
        gq.push_back(0);
        R0_ADDR = 32'h100;
        R0_REQ = 1'b1;
        tick();
        checks++;
        if (R0_GNT !== 1'b1 || M_AXI_ARVALID !== 1'b1 ||
            M_AXI_ARADDR !== 32'h100 || M_AXI_ARID !== 1'b0) begin
            failures++;
            $display("FAIL single_c1: got gnt=%0b arv=%0b addr=%h id=%0d, expected 1 1 100 0",
                     R0_GNT, M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARID);
        end
        R0_REQ = 1'b0;
        tick();
        checks++;
        if (M_AXI_RREADY !== 1'b1 || M_AXI_ARVALID !== 1'b0) begin
            failures++;
            $display("FAIL single_c2: got rready=%0b arvalid=%0b, expected 1 0",
                     M_AXI_RREADY, M_AXI_ARVALID);
        end
        tick();
        checks++;
        if (R0_VALID !== 1'b1 || R0_DATA !== 32'hDEADBEEF || R0_RESP !== 2'b00) begin
            failures++;
            $display("FAIL single_c3: got v=%0b d=%h r=%0d, expected 1 deadbeef 0",
                     R0_VALID, R0_DATA, R0_RESP);
        end
        checks++;
        if (R1_VALID !== 1'b0 || R1_DATA !== 32'h0 || R1_RESP !== 2'b0) begin
            failures++;
            $display("FAIL single_r1: got v=%0b d=%h r=%0d, expected 0 0 0",
                     R1_VALID, R1_DATA, R1_RESP);
        end
        tick();
        checks++;
        if (R0_VALID !== 1'b0) begin
            failures++;
            $display("FAIL single_pulse: got valid=%0b, expected 0", R0_VALID);
        end
        drain();
    endtask

    task automatic test_contention();
        exp_t e;
        int   n;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            e.port = i % 2;
            e.data = fdat((i % 2) ? 32'h20 : 32'h10);
            e.resp = RESP_OKAY;
            sb.push_back(e);
            gq.push_back(i % 2);
        end
        R0_ADDR = 32'h10;
        R1_ADDR = 32'h20;
        R0_REQ = 1'b1;
        R1_REQ = 1'b1;
        n = 0;
        for (int c = 0; c < 200 && n < 8; c++) begin
            tick();
            if (R0_GNT || R1_GNT) begin
                n++;
                if (n <= 2) begin
                    checks++;
                    if (M_AXI_ARID !== n - 1 ||
                        M_AXI_ARADDR !== (n == 1 ? 32'h10 : 32'h20)) begin
                        failures++;
                        $display("FAIL cont_ar%0d: got id=%0d addr=%h, expected id=%0d",
                                 n, M_AXI_ARID, M_AXI_ARADDR, n - 1);
                    end
                end
            end
        end
        R0_REQ = 1'b0;
        R1_REQ = 1'b0;
        checks++;
        if (n != 8) begin
            failures++;
            $display("FAIL cont_count: got %0d grants, expected 8", n);
        end
        drain();
    endtask

    task automatic test_ar_stall();
        ar_wait = 5;
        issue(0, 32'h200, RESP_OKAY);
        R0_ADDR = 32'h300;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (M_AXI_ARVALID !== 1'b1 || M_AXI_ARADDR !== 32'h200) begin
                failures++;
                $display("FAIL ar_stall%0d: got arv=%0b addr=%h, expected 1 200",
                         i, M_AXI_ARVALID, M_AXI_ARADDR);
            end
            tick();
        end
        drain();
        ar_wait = 0;
    endtask

    task automatic test_r_delay();
        r_wait = 7;
        resp_cfg = RESP_SLVERR;
        issue(1, 32'h40, RESP_SLVERR);
        tick();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (M_AXI_RREADY !== 1'b1 || R1_VALID !== 1'b0) begin
                failures++;
                $display("FAIL rdly_wait%0d: got rready=%0b valid=%0b, expected 1 0",
                         i, M_AXI_RREADY, R1_VALID);
            end
            tick();
        end
        checks++;
        if (R1_VALID !== 1'b1 || R1_RESP !== 2'b10 || M_AXI_RREADY !== 1'b0) begin
            failures++;
            $display("FAIL rdly_done: got v=%0b resp=%0d rready=%0b, expected 1 2 0",
                     R1_VALID, R1_RESP, M_AXI_RREADY);
        end
        tick();
        checks++;
        if (R1_VALID !== 1'b0 || ERR_RLAST !== 1'b0) begin
            failures++;
            $display("FAIL rdly_after: got v=%0b err=%0b, expected 0 0",
                     R1_VALID, ERR_RLAST);
        end
        drain();
        r_wait = 0;
        resp_cfg = RESP_OKAY;
    endtask

    task automatic test_rlast_err();
        rlast_cfg = 1'b0;
        issue(0, 32'h80, RESP_OKAY);
        drain();
        checks++;
        if (ERR_RLAST !== 1'b1) begin
            failures++;
            $display("FAIL rlast_set: got %0b, expected 1", ERR_RLAST);
        end
        rlast_cfg = 1'b1;
        issue(1, 32'h84, RESP_OKAY);
        drain();
        checks++;
        if (ERR_RLAST !== 1'b1) begin
            failures++;
            $display("FAIL rlast_sticky: got %0b, expected 1", ERR_RLAST);
        end
    endtask

    task automatic test_rst_mid();
        exp_t e;
        int   n;
        r_wait = 4;
        issue(0, 32'h90, RESP_OKAY);
        for (int i = 0; i < 10 && !M_AXI_RREADY; i++) tick();
        tick();
        RST = 1'b1;
        sb.delete();
        gq.delete();
        tick();
        checks++;
        if (M_AXI_ARVALID !== 1'b0 || M_AXI_RREADY !== 1'b0 ||
            R0_VALID !== 1'b0 || ERR_RLAST !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid: got arv=%0b rr=%0b v=%0b err=%0b, expected 0",
                     M_AXI_ARVALID, M_AXI_RREADY, R0_VALID, ERR_RLAST);
        end
        tick();
        RST = 1'b0;
        r_wait = 0;
        tick();
        checks++;
        if (R0_VALID !== 1'b0 || R1_VALID !== 1'b0) begin
            failures++;
            $display("FAIL rst_novalid: got %0b%0b, expected 00", R0_VALID, R1_VALID);
        end
        for (int i = 0; i < 2; i++) begin
            e.port = i;
            e.data = fdat(i == 1 ? 32'h20 : 32'h10);
            e.resp = RESP_OKAY;
            sb.push_back(e);
            gq.push_back(i);
        end
        R0_ADDR = 32'h10;
        R1_ADDR = 32'h20;
        R0_REQ = 1'b1;
        R1_REQ = 1'b1;
        n = 0;
        for (int c = 0; c < 60 && n < 2; c++) begin
            tick();
            if (R0_GNT) begin
                R0_REQ = 1'b0;
                n++;
            end
            if (R1_GNT) begin
                R1_REQ = 1'b0;
                n++;
            end
        end
        R0_REQ = 1'b0;
        R1_REQ = 1'b0;
        drain();
    endtask

    initial begin
        RST = 1'b1;
        R0_REQ = 1'b0;
        R1_REQ = 1'b0;
        R0_ADDR = '0;
        R1_ADDR = '0;
        test_reset();
        test_single();
        test_contention();
        test_ar_stall();
        test_r_delay();
        test_rlast_err();
        test_rst_mid();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
